// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the SPI/CPU register bank arbiter.
package reg_bank_pkg;

    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_REG_W  = 8;
    localparam int unsigned CNT_W      = 4;

    // Bit positions inside the 8-bit status byte
    localparam int unsigned ST_PEND    = 0;
    localparam int unsigned ST_BUSY    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ARB  = 2'd1,
        BUS_RESP = 2'd2
    } bus_state_t;

endpackage

// File: rtl/reg_bank_arbiter_rr.sv
// Two-requester round-robin arbiter; priority moves away from whichever side was just granted.
module rr_arbiter2 (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic req_spi,
    input  logic req_bus,
    output logic gnt_spi_c,
    output logic gnt_bus_c
);

    // ptr_bus=0: SPI wins a conflict; reset favours SPI
    logic ptr_bus;

    always_comb begin
        gnt_spi_c = 1'b0;
        gnt_bus_c = 1'b0;
        if (ena) begin
            if (req_spi && (!req_bus || !ptr_bus)) begin
                gnt_spi_c = 1'b1;
            end else if (req_bus) begin
                gnt_bus_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            ptr_bus <= 1'b0;
        end else if (gnt_spi_c) begin
            ptr_bus <= 1'b1;
        end else if (gnt_bus_c) begin
            ptr_bus <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shared register bank between an unstallable SPI write port and a handshaked CPU bus.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned REG_W  = DEF_REG_W
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic [ADDR_W-1:0]             spi_addr,
    input  logic [REG_W-1:0]              spi_wdata,
    input  logic                          spi_wr_dv,
    output logic [REG_W-1:0]              spi_rdata,
    input  logic [ADDR_W-1:0]             bus_addr,
    input  logic [REG_W-1:0]              bus_wdata,
    input  logic                          bus_wr,
    input  logic                          bus_rd,
    output logic [REG_W-1:0]              bus_rdata,
    output logic                          bus_ready,
    input  logic                          clr_ovf,
    output logic [7:0]                    status,
    output logic [(REG_W << ADDR_W)-1:0]  regs_q
);

    localparam int unsigned NREG = 1 << ADDR_W;

    bus_state_t         state;
    bus_state_t         state_nx;
    logic [REG_W-1:0]   bank [NREG];
    logic [ADDR_W-1:0]  slot_addr;
    logic [REG_W-1:0]   slot_data;
    logic               spi_pend;
    logic               spi_ovf;
    logic               bus_busy;
    logic [CNT_W-1:0]   spi_wr_cnt;
    logic               gnt_spi_c;
    logic               gnt_bus_c;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [REG_W-1:0]   wr_data;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .req_spi   (spi_pend),
        .req_bus   (state == BUS_ARB),
        .gnt_spi_c (gnt_spi_c),
        .gnt_bus_c (gnt_bus_c)
    );

    // Bus FSM state register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= BUS_IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            BUS_IDLE: if (bus_wr || bus_rd) state_nx = BUS_ARB;
            BUS_ARB:  if (gnt_bus_c)        state_nx = BUS_RESP;
            BUS_RESP:                       state_nx = BUS_IDLE;
            default:                        state_nx = BUS_IDLE;
        endcase
    end

    // Single bank write port: at most one grant per cycle
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = slot_addr;
        wr_data = slot_data;
        if (gnt_spi_c) begin
            wr_en = 1'b1;
        end else if (gnt_bus_c && bus_wr) begin
            wr_en   = 1'b1;
            wr_addr = bus_addr;
            wr_data = bus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_addr] <= wr_data;
        end
    end

    // Bus response registers; read data is sampled at grant time
    always_ff @(posedge clk) begin
        if (!rstb) begin
            bus_ready <= 1'b0;
            bus_rdata <= '0;
            bus_busy  <= 1'b0;
        end else if (ena) begin
            bus_ready <= gnt_bus_c;
            bus_rdata <= (gnt_bus_c && bus_rd) ? bank[bus_addr] : '0;
            bus_busy  <= (state_nx != BUS_IDLE);
        end
    end

    // SPI pending slot: a new strobe always loads; it only overflows if the old entry is not leaving
    always_ff @(posedge clk) begin
        if (!rstb) begin
            slot_addr  <= '0;
            slot_data  <= '0;
            spi_pend   <= 1'b0;
            spi_ovf    <= 1'b0;
            spi_wr_cnt <= '0;
        end else if (ena) begin
            if (spi_wr_dv) begin
                slot_addr <= spi_addr;
                slot_data <= spi_wdata;
                spi_pend  <= 1'b1;
            end else if (gnt_spi_c) begin
                spi_pend  <= 1'b0;
            end
            if (spi_wr_dv && spi_pend && !gnt_spi_c) begin
                spi_ovf <= 1'b1;
            end else if (clr_ovf) begin
                spi_ovf <= 1'b0;
            end
            if (gnt_spi_c) begin
                spi_wr_cnt <= spi_wr_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        status                         = '0;
        status[ST_PEND]                = spi_pend;
        status[ST_BUSY]                = bus_busy;
        status[ST_OVF]                 = spi_ovf;
        status[ST_CNT_LSB +: CNT_W]    = spi_wr_cnt;
    end

    assign spi_rdata = bank[spi_addr];

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_q[g*REG_W +: REG_W] = bank[g];
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: bus responses checked by a monitor, state checked inline.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rstb;
    logic        ena;
    logic [2:0]  spi_addr;
    logic [7:0]  spi_wdata;
    logic        spi_wr_dv;
    logic [7:0]  spi_rdata;
    logic [2:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [7:0]  bus_rdata;
    logic        bus_ready;
    logic        clr_ovf;
    logic [7:0]  status;
    logic [63:0] regs_q;

    int          n_cmp;
    int          n_err;
    logic [7:0]  exp_q [$];

    reg_bank_arbiter dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_wr_dv (spi_wr_dv),
        .spi_rdata (spi_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .clr_ovf   (clr_ovf),
        .status    (status),
        .regs_q    (regs_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rg(input int i);
        return regs_q[i*8 +: 8];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pops one expected read value per bus_ready pulse
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_bus_ready: got 1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("bus_rdata", 64'(bus_rdata), 64'(e));
                end
            end
        end
    endtask

    task automatic spi_wr(input logic [2:0] a, input logic [7:0] d);
        spi_addr  = a;
        spi_wdata = d;
        spi_wr_dv = 1'b1;
        @(negedge clk);
        spi_wr_dv = 1'b0;
    endtask

    task automatic bus_op(input logic wr, input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int exp_lat);
        int lat;
        exp_q.push_back(wr ? 8'h00 : exp_rd);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = wr;
        bus_rd    = !wr;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("bus_busy_arb", 64'(status[1]), 64'd1);
        end while (bus_ready !== 1'b1 && lat < 20);
        chk("bus_latency", 64'(lat), 64'(exp_lat));
        bus_wr = 1'b0;
        bus_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic stim();
        // Reset state
        rstb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_regs", regs_q, 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_ready", 64'(bus_ready), 64'd0);
        chk("rst_rdata", 64'(bus_rdata), 64'd0);
        rstb = 1'b1;

        // Single SPI write
        spi_addr  = 3'd3;
        spi_wdata = 8'hA5;
        spi_wr_dv = 1'b1;
        @(negedge clk);
        spi_wr_dv = 1'b0;
        chk("spi_pend_set", 64'(status), 64'h01);
        chk("spi_not_fwd", 64'(spi_rdata), 64'h00);
        @(negedge clk);
        chk("spi_commit", 64'(rg(3)), 64'hA5);
        chk("spi_status", 64'(status), 64'h10);
        chk("spi_rdata", 64'(spi_rdata), 64'hA5);

        // Bus write then read back
        bus_op(1'b1, 3'd5, 8'h3C, 8'h00, 2);
        chk("bus_wr_bank", 64'(rg(5)), 64'h3C);
        bus_op(1'b0, 3'd5, 8'h00, 8'h3C, 2);
        chk("rdata_idle_zero", 64'(bus_rdata), 64'h00);

        // SPI and bus write same address, same cycle: SPI first
        do_reset();
        exp_q.push_back(8'h00);
        spi_addr  = 3'd1; spi_wdata = 8'h55; spi_wr_dv = 1'b1;
        bus_addr  = 3'd1; bus_wdata = 8'h99; bus_wr    = 1'b1;
        @(negedge clk);
        spi_wr_dv = 1'b0;
        chk("conf_t0_bank", 64'(rg(1)), 64'h00);
        @(negedge clk);
        chk("conf_spi_first", 64'(rg(1)), 64'h55);
        chk("conf_no_ready", 64'(bus_ready), 64'd0);
        @(negedge clk);
        chk("conf_ready", 64'(bus_ready), 64'd1);
        chk("conf_bus_last", 64'(rg(1)), 64'h99);
        bus_wr = 1'b0;
        @(negedge clk);
        chk("conf_status", 64'(status), 64'h10);

        // Slot overwrite while the bus holds the grant
        do_reset();
        exp_q.push_back(8'h00);
        spi_addr = 3'd2; spi_wdata = 8'h11; spi_wr_dv = 1'b1;
        bus_addr = 3'd7; bus_wdata = 8'h77; bus_wr    = 1'b1;
        @(negedge clk);
        spi_addr = 3'd4; spi_wdata = 8'h22;
        @(negedge clk);
        spi_addr = 3'd6; spi_wdata = 8'h33;
        @(negedge clk);
        spi_wr_dv = 1'b0;
        chk("ovf_status", 64'(status), 64'h17);
        bus_wr = 1'b0;
        @(negedge clk);
        chk("ovf_after", 64'(status), 64'h24);
        chk("ovf_bank2", 64'(rg(2)), 64'h11);
        chk("ovf_bank4", 64'(rg(4)), 64'h00);
        chk("ovf_bank6", 64'(rg(6)), 64'h33);
        chk("ovf_bank7", 64'(rg(7)), 64'h77);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", 64'(status), 64'h20);

        // 17 SPI commits wrap the counter to 1
        do_reset();
        spi_wr_dv = 1'b1;
        for (int i = 0; i < 17; i++) begin
            spi_addr  = 3'(i % 8);
            spi_wdata = 8'(i);
            @(negedge clk);
        end
        spi_wr_dv = 1'b0;
        @(negedge clk);
        chk("wrap_status", 64'(status), 64'h10);
        chk("wrap_bank0", 64'(rg(0)), 64'h10);
        chk("wrap_bank7", 64'(rg(7)), 64'h0F);

        // ena low for 5 cycles while in ARB
        exp_q.push_back(8'h00);
        bus_addr = 3'd2; bus_wdata = 8'hC3; bus_wr = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        spi_addr = 3'd5; spi_wdata = 8'hEE; spi_wr_dv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ready", 64'(bus_ready), 64'd0);
            chk("hold_status", 64'(status), 64'h12);
        end
        chk("hold_bank2", 64'(rg(2)), 64'h0A);
        spi_wr_dv = 1'b0;
        ena = 1'b1;
        @(negedge clk);
        chk("resume_ready", 64'(bus_ready), 64'd1);
        chk("resume_bank2", 64'(rg(2)), 64'hC3);
        bus_wr = 1'b0;
        @(negedge clk);
        chk("resume_bank5", 64'(rg(5)), 64'h0D);
        chk("resume_status", 64'(status), 64'h10);
        bus_op(1'b0, 3'd2, 8'h00, 8'hC3, 2);

        // Reset while in ARB drops the write
        bus_addr = 3'd0; bus_wdata = 8'hFF; bus_wr = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        bus_wr = 1'b0;
        chk("rarb_ready", 64'(bus_ready), 64'd0);
        chk("rarb_regs", regs_q, 64'd0);
        chk("rarb_status", 64'(status), 64'd0);
        rstb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rarb_no_write", 64'(rg(0)), 64'h00);

        // Reset during the RESP cycle
        exp_q.push_back(8'h00);
        bus_addr = 3'd4; bus_wdata = 8'h44; bus_wr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rresp_ready_seen", 64'(bus_ready), 64'd1);
        rstb = 1'b0;
        bus_wr = 1'b0;
        @(negedge clk);
        chk("rresp_ready", 64'(bus_ready), 64'd0);
        chk("rresp_regs", regs_q, 64'd0);
        chk("rresp_status", 64'(status), 64'd0);
        rstb = 1'b1;
        @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rstb      = 1'b0;
        ena       = 1'b1;
        spi_addr  = '0;
        spi_wdata = '0;
        spi_wr_dv = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        clr_ovf   = 1'b0;
        fork
            monitor();
            stim();
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
